decode_issue_ctrl: RTL and testbench
====================================

DECODE_ISSUE_CTRL -- requirements
Module: decode_issue_ctrl

Interface
REQ-001 Parameter NREGS, 32, architectural register count; register 0 is hardwired zero.
REQ-002 Parameter RADDR_W, 5, register index width, equal to clog2(NREGS).
REQ-003 Port clock  in  1  single clock; all state updates on the rising edge.
REQ-004 Port reset_n  in  1  reset, asynchronous and active-low.
REQ-005 Port dec_valid  in  1  decoded instruction present at the decode outputs.
REQ-006 Port dec_rs, dec_rt  in  RADDR_W each  source register indices.
REQ-007 Port dec_use_rs, dec_use_rt  in  1 each  the instruction reads the corresponding source.
REQ-008 Port dec_wr_en, dec_wr_reg  in  1 / RADDR_W  the instruction writes dec_wr_reg.
REQ-009 Port dec_illegal  in  1  decode flagged an illegal opcode.
REQ-010 Port exe_ready  in  1  execute stage accepts an issued instruction this cycle.
REQ-011 Port wb_valid, wb_reg  in  1 / RADDR_W  writeback retires a write to wb_reg.
REQ-012 Port issue  out  1  instruction transferred to execute this cycle.
REQ-013 Port stall  out  1  hold fetch and decode; pc must not advance.
REQ-014 Port halted  out  1  controller is in HALT.
REQ-015 Port pending  out  NREGS  scoreboard; bit i set means a write to register i is outstanding.

Function
REQ-016 The controller has three states: RUN, STALL and HALT.
REQ-017 hazard = dec_valid AND (RAW on rs, RAW on rt, or WAW on wr_reg against pending), evaluated after same-cycle writeback bypass (REQ-022).
REQ-018 In RUN or STALL with dec_valid, no hazard, exe_ready=1 and dec_illegal=0, issue=1 combinationally and the state is RUN next cycle.
REQ-019 In RUN or STALL with dec_valid and either a hazard or exe_ready=0, issue=0, stall=1 and the state is STALL next cycle.
REQ-020 When dec_valid=0, issue=0, stall=0 and the state goes to RUN; dec_illegal is ignored in this case.
REQ-021 dec_valid AND dec_illegal in RUN or STALL gives issue=0 and stall=1, and the state is HALT next cycle; HALT is left only by reset.
REQ-022 A wb_valid for register r clears pending[r] at the edge, and a same-cycle decode reading or writing r sees r as not pending.
REQ-023 An issue with dec_wr_en sets pending[dec_wr_reg] at the edge.
REQ-024 When the set of REQ-023 and the clear of REQ-022 hit the same register in one cycle, the set wins and the bit stays 1.
REQ-025 Register 0 never sets pending and never causes a hazard; pending[0] is always 0.
REQ-026 wb_valid for a register that is not pending is ignored, with no error.
REQ-027 In HALT, issue=0, stall=1 and halted=1; writebacks still clear pending bits.
REQ-028 issue, stall and halted are combinational from the current state and inputs, with zero-cycle latency; there is no output register.
REQ-029 issue and stall are never 1 in the same cycle.

Reset
REQ-030 While reset_n=0, the state is RUN, pending is all zeros, and issue, stall and halted are 0, all asynchronously.
REQ-031 Reset asserted in mid-STALL or in HALT discards all outstanding pending state; the first edge after release acts as RUN.

Structure
REQ-032 The state encoding, NREGS and RADDR_W defaults go in a shared package, pipeline_pkg, that is reused by fetch and decode.
REQ-033 The scoreboard (pending vector with set, clear and bypass-aware lookup) is one sub-module, named scoreboard; the FSM and issue logic stay in decode_issue_ctrl.

Verification
REQ-034 RAW stall: issue wr r5; next instruction reads rs=5 -> stall=1 each cycle until wb_valid with wb_reg=5; it issues in that same cycle.
REQ-035 Backpressure: dec_valid=1, no hazard, exe_ready=0 for 3 cycles -> stall=1 for 3 cycles, then issue=1 in the cycle exe_ready=1.
REQ-036 Simultaneous set/clear: r7 pending; issue wr r7 while wb_reg=7 -> pending[7]=1 afterwards.
REQ-037 Zero register: instruction writing r0, then one reading r0 -> both issue back-to-back and pending[0] stays 0.
REQ-038 Illegal: dec_illegal=1 with dec_valid -> halted=1 and stall=1 from the next cycle; writebacks still clear bits; reset_n low -> RUN with pending=0.
REQ-039 WAW: r3 pending; new instruction writes r3 with no source reads -> stall until wb_reg=3.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions used by fetch, decode and the issue controller.
package pipeline_pkg;

  localparam int unsigned DefaultNregs  = 32;
  localparam int unsigned DefaultRaddrW = $clog2(DefaultNregs);

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StHalt  = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/scoreboard.sv
// Register scoreboard: one pending bit per architectural register, with set,
// clear and a lookup that already sees a same-cycle writeback as retired.
module scoreboard
  import pipeline_pkg::*;
#(
  parameter int unsigned NREGS   = DefaultNregs,
  parameter int unsigned RADDR_W = DefaultRaddrW
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               set_en_i,
  input  logic [RADDR_W-1:0] set_reg_i,
  input  logic               clr_en_i,
  input  logic [RADDR_W-1:0] clr_reg_i,
  input  logic [RADDR_W-1:0] rs_i,
  input  logic [RADDR_W-1:0] rt_i,
  input  logic [RADDR_W-1:0] wr_reg_i,
  output logic               rs_busy_o,
  output logic               rt_busy_o,
  output logic               wr_busy_o,
  output logic [NREGS-1:0]   pending_o
);

  logic [NREGS-1:0] pending_q, pending_d;
  logic [NREGS-1:0] set_mask, clr_mask, view;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en_i && (set_reg_i != '0)) set_mask[set_reg_i] = 1'b1;
    if (clr_en_i) clr_mask[clr_reg_i] = 1'b1;

    // Bypassed view: a writeback landing this cycle no longer blocks decode.
    view    = pending_q & ~clr_mask;
    view[0] = 1'b0;

    // Set is applied after clear so a re-issued write keeps the bit high.
    pending_d    = (pending_q & ~clr_mask) | set_mask;
    pending_d[0] = 1'b0;
  end

  assign rs_busy_o = view[rs_i];
  assign rt_busy_o = view[rt_i];
  assign wr_busy_o = view[wr_reg_i];
  assign pending_o = pending_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode-to-execute issue controller: hazard detection against the scoreboard,
// backpressure handling and halt on illegal opcodes.
module decode_issue_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned NREGS   = DefaultNregs,
  parameter int unsigned RADDR_W = DefaultRaddrW
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               dec_valid,
  input  logic [RADDR_W-1:0] dec_rs,
  input  logic [RADDR_W-1:0] dec_rt,
  input  logic               dec_use_rs,
  input  logic               dec_use_rt,
  input  logic               dec_wr_en,
  input  logic [RADDR_W-1:0] dec_wr_reg,
  input  logic               dec_illegal,
  input  logic               exe_ready,
  input  logic               wb_valid,
  input  logic [RADDR_W-1:0] wb_reg,
  output logic               issue,
  output logic               stall,
  output logic               halted,
  output logic [NREGS-1:0]   pending
);

  ctrl_state_e state_q, state_d;
  logic        rs_busy, rt_busy, wr_busy;
  logic        hazard;

  scoreboard #(
    .NREGS   (NREGS),
    .RADDR_W (RADDR_W)
  ) u_scoreboard (
    .clock     (clock),
    .reset_n   (reset_n),
    .set_en_i  (issue & dec_wr_en),
    .set_reg_i (dec_wr_reg),
    .clr_en_i  (wb_valid),
    .clr_reg_i (wb_reg),
    .rs_i      (dec_rs),
    .rt_i      (dec_rt),
    .wr_reg_i  (dec_wr_reg),
    .rs_busy_o (rs_busy),
    .rt_busy_o (rt_busy),
    .wr_busy_o (wr_busy),
    .pending_o (pending)
  );

  assign hazard = dec_valid &
                  ((dec_use_rs & rs_busy) | (dec_use_rt & rt_busy) | (dec_wr_en & wr_busy));

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    stall   = 1'b0;
    halted  = 1'b0;
    unique case (state_q)
      StRun, StStall: begin
        if (!dec_valid) begin
          state_d = StRun;
        end else if (dec_illegal) begin
          stall   = 1'b1;
          state_d = StHalt;
        end else if (hazard || !exe_ready) begin
          stall   = 1'b1;
          state_d = StStall;
        end else begin
          issue   = 1'b1;
          state_d = StRun;
        end
      end
      StHalt: begin
        stall  = 1'b1;
        halted = 1'b1;
      end
      default: state_d = StRun;
    endcase
    // Outputs must read idle for the whole reset window, not just after an edge.
    if (!reset_n) begin
      issue  = 1'b0;
      stall  = 1'b0;
      halted = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Bench for decode_issue_ctrl: directed scenarios plus randomized traffic
// checked against a pending-set / halted-flag reference model.
module tb_decode_issue_ctrl;

  localparam int unsigned NR = 32;
  localparam int unsigned AW = 5;

  logic          clock, reset_n;
  logic          dec_valid, dec_use_rs, dec_use_rt, dec_wr_en, dec_illegal, exe_ready, wb_valid;
  logic [AW-1:0] dec_rs, dec_rt, dec_wr_reg, wb_reg;
  logic          issue, stall, halted;
  logic [NR-1:0] pending;

  int unsigned   vectors = 0;
  int unsigned   miscompares = 0;
  logic [NR-1:0] mdl_pend;
  bit            mdl_halt;

  decode_issue_ctrl #(
    .NREGS   (NR),
    .RADDR_W (AW)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .dec_valid   (dec_valid),
    .dec_rs      (dec_rs),
    .dec_rt      (dec_rt),
    .dec_use_rs  (dec_use_rs),
    .dec_use_rt  (dec_use_rt),
    .dec_wr_en   (dec_wr_en),
    .dec_wr_reg  (dec_wr_reg),
    .dec_illegal (dec_illegal),
    .exe_ready   (exe_ready),
    .wb_valid    (wb_valid),
    .wb_reg      (wb_reg),
    .issue       (issue),
    .stall       (stall),
    .halted      (halted),
    .pending     (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic drive(input bit v, input bit ill, input bit rdy, input bit urs,
                       input logic [AW-1:0] rs, input bit urt, input logic [AW-1:0] rt,
                       input bit we, input logic [AW-1:0] wr, input bit wbv,
                       input logic [AW-1:0] wbr);
    dec_valid = v;   dec_illegal = ill; exe_ready = rdy;
    dec_use_rs = urs; dec_rs = rs;      dec_use_rt = urt; dec_rt = rt;
    dec_wr_en = we;  dec_wr_reg = wr;   wb_valid = wbv;   wb_reg = wbr;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, '0, 0, '0, 0, '0, 0, '0);
  endtask

  // Register r blocks decode if a write is outstanding and not retiring now.
  function automatic bit mdl_busy(input logic [AW-1:0] r);
    return (r != '0) && mdl_pend[r] && !(wb_valid && wb_reg == r);
  endfunction

  // Expected {issue, stall, halted} for the current inputs.
  function automatic logic [2:0] mdl_out();
    if (!reset_n) return 3'b000;
    if (mdl_halt) return 3'b011;
    if (!dec_valid) return 3'b000;
    if (dec_illegal) return 3'b010;
    if ((dec_use_rs && mdl_busy(dec_rs)) || (dec_use_rt && mdl_busy(dec_rt)) ||
        (dec_wr_en && mdl_busy(dec_wr_reg)) || !exe_ready) return 3'b010;
    return 3'b100;
  endfunction

  task automatic tick();
    logic [2:0] e;
    e = mdl_out();
    @(posedge clock);
    if (reset_n) begin
      if (wb_valid) mdl_pend[wb_reg] = 1'b0;
      if (e[2] && dec_wr_en && dec_wr_reg != '0) mdl_pend[dec_wr_reg] = 1'b1;
      if (!mdl_halt && dec_valid && dec_illegal) mdl_halt = 1'b1;
    end
    @(negedge clock);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    idle();
    mdl_pend = '0;
    mdl_halt = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset_n = 1'b0;
    drive(1, 0, 1, 0, '0, 0, '0, 1, 5'd4, 0, '0);
    vectors++; if ({issue, stall, halted} !== 3'b000) begin miscompares++;
      $display("FAIL reset_outputs: got %b expected 000", {issue, stall, halted}); end
    drive(1, 1, 1, 0, '0, 0, '0, 0, '0, 0, '0);
    vectors++; if (stall !== 1'b0) begin miscompares++;
      $display("FAIL reset_illegal_stall: got %b expected 0", stall); end
    @(posedge clock);
    #1;
    vectors++; if (pending !== '0) begin miscompares++;
      $display("FAIL reset_pending: got %h expected 0", pending); end
    apply_reset();
  endtask

  task automatic test_raw();
    apply_reset();
    drive(1, 0, 1, 0, '0, 0, '0, 1, 5'd5, 0, '0);
    vectors++; if (issue !== 1'b1) begin miscompares++;
      $display("FAIL raw_first_issue: got %b expected 1", issue); end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 1, 5'd5, 0, '0, 0, '0, 0, '0);
      vectors++; if ({issue, stall} !== 2'b01) begin miscompares++;
        $display("FAIL raw_stall[%0d]: got issue/stall %b expected 01", i, {issue, stall}); end
      tick();
    end
    drive(1, 0, 1, 1, 5'd5, 0, '0, 0, '0, 1, 5'd5);
    vectors++; if ({issue, stall} !== 2'b10) begin miscompares++;
      $display("FAIL raw_bypass_issue: got issue/stall %b expected 10", {issue, stall}); end
    tick();
    vectors++; if (pending[5] !== 1'b0) begin miscompares++;
      $display("FAIL raw_cleared: got %b expected 0", pending[5]); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 1, 5'd1, 1, 5'd2, 1, 5'd6, 0, '0);
      vectors++; if ({issue, stall} !== 2'b01) begin miscompares++;
        $display("FAIL bp_stall[%0d]: got issue/stall %b expected 01", i, {issue, stall}); end
      tick();
    end
    drive(1, 0, 1, 1, 5'd1, 1, 5'd2, 1, 5'd6, 0, '0);
    vectors++; if ({issue, stall} !== 2'b10) begin miscompares++;
      $display("FAIL bp_issue: got issue/stall %b expected 10", {issue, stall}); end
    tick();
    vectors++; if (pending !== 32'h0000_0040) begin miscompares++;
      $display("FAIL bp_pending: got %h expected 00000040", pending); end
  endtask

  task automatic test_set_clear();
    apply_reset();
    drive(1, 0, 1, 0, '0, 0, '0, 1, 5'd7, 0, '0);
    tick();
    drive(1, 0, 1, 0, '0, 0, '0, 1, 5'd7, 1, 5'd7);
    vectors++; if (issue !== 1'b1) begin miscompares++;
      $display("FAIL setclr_issue: got %b expected 1", issue); end
    tick();
    vectors++; if (pending[7] !== 1'b1) begin miscompares++;
      $display("FAIL setclr_pending7: got %b expected 1", pending[7]); end
  endtask

  task automatic test_zero_reg();
    apply_reset();
    drive(1, 0, 1, 0, '0, 0, '0, 1, 5'd0, 0, '0);
    vectors++; if (issue !== 1'b1) begin miscompares++;
      $display("FAIL zero_write_issue: got %b expected 1", issue); end
    tick();
    drive(1, 0, 1, 1, 5'd0, 1, 5'd0, 1, 5'd0, 0, '0);
    vectors++; if (issue !== 1'b1) begin miscompares++;
      $display("FAIL zero_read_issue: got %b expected 1", issue); end
    tick();
    vectors++; if (pending !== '0) begin miscompares++;
      $display("FAIL zero_pending: got %h expected 0", pending); end
  endtask

  task automatic test_waw();
    apply_reset();
    drive(1, 0, 1, 0, '0, 0, '0, 1, 5'd3, 0, '0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 1, 0, '0, 0, '0, 1, 5'd3, 1, 5'd8);
      vectors++; if ({issue, stall} !== 2'b01) begin miscompares++;
        $display("FAIL waw_stall[%0d]: got issue/stall %b expected 01", i, {issue, stall}); end
      tick();
    end
    drive(1, 0, 1, 0, '0, 0, '0, 1, 5'd3, 1, 5'd3);
    vectors++; if ({issue, stall} !== 2'b10) begin miscompares++;
      $display("FAIL waw_issue: got issue/stall %b expected 10", {issue, stall}); end
    tick();
  endtask

  task automatic test_illegal();
    apply_reset();
    drive(1, 0, 1, 0, '0, 0, '0, 1, 5'd9, 0, '0);
    tick();
    drive(1, 1, 1, 0, '0, 0, '0, 0, '0, 0, '0);
    vectors++; if ({issue, stall, halted} !== 3'b010) begin miscompares++;
      $display("FAIL ill_detect: got %b expected 010", {issue, stall, halted}); end
    tick();
    drive(1, 0, 1, 0, '0, 0, '0, 1, 5'd10, 1, 5'd9);
    vectors++; if ({issue, stall, halted} !== 3'b011) begin miscompares++;
      $display("FAIL ill_halted: got %b expected 011", {issue, stall, halted}); end
    tick();
    vectors++; if (pending !== '0) begin miscompares++;
      $display("FAIL ill_wb_clear: got %h expected 0", pending); end
    drive(0, 0, 0, 0, '0, 0, '0, 0, '0, 0, '0);
    vectors++; if (halted !== 1'b1) begin miscompares++;
      $display("FAIL ill_sticky: got %b expected 1", halted); end
    tick();
    apply_reset();
    drive(1, 0, 1, 1, 5'd9, 0, '0, 0, '0, 0, '0);
    vectors++; if ({issue, stall, halted} !== 3'b100) begin miscompares++;
      $display("FAIL ill_after_reset: got %b expected 100", {issue, stall, halted}); end
    tick();
  endtask

  task automatic test_random();
    logic [2:0] e;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        apply_reset();
        continue;
      end
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) != 0, AW'($urandom_range(0, 7)),
            $urandom_range(0, 1) != 0, AW'($urandom_range(0, 7)),
            $urandom_range(0, 1) != 0, AW'($urandom_range(0, 7)),
            $urandom_range(0, 2) == 0, AW'($urandom_range(0, 7)));
      e = mdl_out();
      vectors++; if ({issue, stall, halted} !== e) begin miscompares++;
        $display("FAIL rand_out[%0d]: got %b expected %b", i, {issue, stall, halted}, e); end
      vectors++; if (pending !== mdl_pend) begin miscompares++;
        $display("FAIL rand_pending[%0d]: got %h expected %h", i, pending, mdl_pend); end
      tick();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    mdl_pend = '0;
    mdl_halt = 1'b0;
    idle();
    test_reset();
    test_raw();
    test_backpressure();
    test_set_clear();
    test_zero_reg();
    test_waw();
    test_illegal();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
